// File: rtl/dma_row_pkg.sv
// Shared types and widths for the DMA row fetcher.
// State encoding plus the address/data widths used by the top and the row RAM.
package dma_row_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        SPACE,
        DONE
    } state_t;

endpackage

// File: rtl/row_buf_ram.sv
// Two-bank row store: one write port, one registered read port.
// Each bank holds ROW_LEN bytes; the bank bit selects the upper half.
module row_buf_ram
    import dma_row_pkg::*;
#(
    parameter int ROW_LEN = 80
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 * ROW_LEN;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_in_row;

    assign wr_idx = IDX_W'(wr_bank ? ROW_LEN + int'(wr_addr)
                                   : int'(wr_addr));
    assign rd_idx = IDX_W'(rd_bank ? ROW_LEN + int'(rd_addr)
                                   : int'(rd_addr));
    assign rd_in_row = int'(rd_addr) < ROW_LEN;

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_idx] <= wr_data;
    end

    // Addresses past the row end read as zero rather than the other bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data <= '0;
        else if (rd_in_row)
            rd_data <= mem[rd_idx];
        else
            rd_data <= '0;
    end

endmodule

// File: rtl/dma_row_fetcher.sv
// DMA requester filling the back bank of a double-buffered row store
// while the display reads the front bank; banks swap on row_start.
module dma_row_fetcher
    import dma_row_pkg::*;
#(
    parameter int ROW_LEN     = 80,
    parameter int BURST_LEN   = 8,
    parameter int BURST_SPACE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              enable,
    input  logic              row_start,
    output logic              drq,
    input  logic              dack,
    input  logic              iowe_n,
    input  logic [DATA_W-1:0] idata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              row_ready,
    output logic              underrun
);

    localparam int PTR_W = ADDR_W + 1;

    state_t           state;
    logic             bank;
    logic [PTR_W-1:0] wr_ptr;
    logic [7:0]       burst_cnt;
    logic [7:0]       space_cnt;
    logic             capture;
    logic             we;
    logic             bus_idle;

    assign capture  = (state == REQ) && dack && !iowe_n;
    assign we       = enable && !row_start && capture;
    assign bus_idle = iowe_n && !dack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bank      <= 1'b0;
            wr_ptr    <= '0;
            burst_cnt <= '0;
            space_cnt <= '0;
            drq       <= 1'b0;
            row_ready <= 1'b0;
            underrun  <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            drq       <= 1'b0;
            row_ready <= 1'b0;
            underrun  <= 1'b0;
        end else if (row_start) begin
            // Restart in XFER so a cycle already on the bus drains first.
            bank      <= ~bank;
            wr_ptr    <= '0;
            burst_cnt <= '0;
            space_cnt <= '0;
            drq       <= 1'b0;
            row_ready <= 1'b0;
            state     <= XFER;
            if (state == REQ || state == XFER || state == SPACE)
                underrun <= 1'b1;
        end else begin
            unique case (state)
                REQ: begin
                    if (capture) begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        burst_cnt <= burst_cnt + 8'd1;
                        drq       <= 1'b0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (bus_idle) begin
                        if (wr_ptr == PTR_W'(ROW_LEN)) begin
                            state     <= DONE;
                            row_ready <= 1'b1;
                        end else if (burst_cnt == 8'(BURST_LEN)) begin
                            burst_cnt <= '0;
                            if (BURST_SPACE > 0) begin
                                state <= SPACE;
                            end else begin
                                state <= REQ;
                                drq   <= 1'b1;
                            end
                        end else begin
                            state <= REQ;
                            drq   <= 1'b1;
                        end
                    end
                end
                SPACE: begin
                    if (ce) begin
                        if (space_cnt + 8'd1 == 8'(BURST_SPACE)) begin
                            space_cnt <= '0;
                            state     <= REQ;
                            drq       <= 1'b1;
                        end else begin
                            space_cnt <= space_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    row_buf_ram #(
        .ROW_LEN(ROW_LEN)
    ) u_ram (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (we),
        .wr_bank(bank),
        .wr_addr(wr_ptr[ADDR_W-1:0]),
        .wr_data(idata),
        .rd_bank(~bank),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_dma_row_fetcher.sv
// Directed bench for dma_row_fetcher: row fill, burst spacing,
// underrun, collision, disable and asynchronous reset.
module tb_dma_row_fetcher;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b1;

    logic       enable = 1'b0;
    logic       row_start = 1'b0;
    logic       drq;
    logic       dack = 1'b0;
    logic       iowe_n = 1'b1;
    logic [7:0] idata = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data;
    logic       row_ready;
    logic       underrun;

    logic       b_enable = 1'b0;
    logic       b_row_start = 1'b0;
    logic       b_drq;
    logic       b_dack = 1'b0;
    logic       b_iowe_n = 1'b1;
    logic [7:0] b_idata = 8'h00;
    logic [6:0] b_rd_addr = 7'h00;
    logic [7:0] b_rd_data;
    logic       b_row_ready;
    logic       b_underrun;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dma_row_fetcher dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .enable   (enable),
        .row_start(row_start),
        .drq      (drq),
        .dack     (dack),
        .iowe_n   (iowe_n),
        .idata    (idata),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .row_ready(row_ready),
        .underrun (underrun)
    );

    dma_row_fetcher #(
        .ROW_LEN    (16),
        .BURST_LEN  (4),
        .BURST_SPACE(3)
    ) dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .enable   (b_enable),
        .row_start(b_row_start),
        .drq      (b_drq),
        .dack     (b_dack),
        .iowe_n   (b_iowe_n),
        .idata    (b_idata),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .row_ready(b_row_ready),
        .underrun (b_underrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drq();
        int k = 0;
        while (!drq && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drq_wait", 32'(drq), 32'd1);
    endtask

    task automatic dma_byte(input logic [7:0] d, input int hold);
        wait_drq();
        dack   = 1'b1;
        iowe_n = 1'b0;
        idata  = d;
        @(negedge clk);
        chk("drq_after_cap", 32'(drq), 32'd0);
        repeat (hold - 1) @(negedge clk);
        dack   = 1'b0;
        iowe_n = 1'b1;
    endtask

    task automatic pulse_rs();
        row_start = 1'b1;
        @(negedge clk);
        row_start = 1'b0;
    endtask

    initial begin
        int gap;
        int k;

        repeat (2) @(negedge clk);
        chk("rst_drq", 32'(drq), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_row_ready", 32'(row_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_drq", 32'(drq), 32'd0);

        // Burst spacing on the 16-byte, 4-byte-burst instance.
        b_enable    = 1'b1;
        b_row_start = 1'b1;
        @(negedge clk);
        b_row_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            k = 0;
            while (!b_drq && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("b_drq_wait", 32'(b_drq), 32'd1);
            b_dack   = 1'b1;
            b_iowe_n = 1'b0;
            b_idata  = 8'(i);
            @(negedge clk);
            b_dack   = 1'b0;
            b_iowe_n = 1'b1;
            if (i < 15) begin
                gap = 1;
                k = 0;
                while (!b_drq && k < 50) begin
                    @(negedge clk);
                    if (!b_drq) gap++;
                    k++;
                end
                chk($sformatf("gap%0d", i), 32'(gap),
                    (i % 4 == 3) ? 32'd4 : 32'd1);
            end
        end
        @(negedge clk);
        chk("b_row_ready", 32'(b_row_ready), 32'd1);
        chk("b_drq_done", 32'(b_drq), 32'd0);

        // Full row fill with default parameters into bank 1.
        enable = 1'b1;
        pulse_rs();
        chk("rs_lat1", 32'(drq), 32'd0);
        @(negedge clk);
        chk("rs_lat2", 32'(drq), 32'd1);
        for (int i = 0; i < 80; i++)
            dma_byte(8'(i), 2);
        @(negedge clk);
        chk("fill_row_ready", 32'(row_ready), 32'd1);
        chk("fill_drq", 32'(drq), 32'd0);
        repeat (3) @(negedge clk);
        chk("done_drq_hold", 32'(drq), 32'd0);
        chk("fill_underrun", 32'(underrun), 32'd0);

        pulse_rs();
        chk("rs2_row_ready", 32'(row_ready), 32'd0);
        rd_addr = 7'h4F;
        @(negedge clk);
        chk("rd_4f", 32'(rd_data), 32'h4F);
        rd_addr = 7'h10;
        @(negedge clk);
        chk("rd_10", 32'(rd_data), 32'h10);
        rd_addr = 7'h50;
        @(negedge clk);
        chk("rd_oob_50", 32'(rd_data), 32'h00);
        rd_addr = 7'h7F;
        @(negedge clk);
        chk("rd_oob_7f", 32'(rd_data), 32'h00);

        // Underrun: row_start while the 30th cycle is still on the bus.
        for (int i = 0; i < 29; i++)
            dma_byte(8'h80 + 8'(i), 2);
        wait_drq();
        dack   = 1'b1;
        iowe_n = 1'b0;
        idata  = 8'h9D;
        @(negedge clk);
        pulse_rs();
        chk("ur_set", 32'(underrun), 32'd1);
        chk("ur_drq", 32'(drq), 32'd0);
        rd_addr = 7'h05;
        @(negedge clk);
        chk("ur_drq_inflight", 32'(drq), 32'd0);
        chk("ur_front_swap", 32'(rd_data), 32'h85);
        dack   = 1'b0;
        iowe_n = 1'b1;
        @(negedge clk);
        chk("ur_drq_rerise", 32'(drq), 32'd1);

        // Collision: row_start in the same clk as a capture of 0xAA.
        dack      = 1'b1;
        iowe_n    = 1'b0;
        idata     = 8'hAA;
        row_start = 1'b1;
        @(negedge clk);
        row_start = 1'b0;
        dack      = 1'b0;
        iowe_n    = 1'b1;
        chk("col_drq", 32'(drq), 32'd0);
        rd_addr = 7'h00;
        @(negedge clk);
        chk("col_no_aa", 32'(rd_data), 32'h00);
        chk("col_underrun", 32'(underrun), 32'd1);
        dma_byte(8'h55, 1);
        wait_drq();
        pulse_rs();
        rd_addr = 7'h00;
        @(negedge clk);
        chk("col_addr0", 32'(rd_data), 32'h55);
        rd_addr = 7'h01;
        @(negedge clk);
        chk("col_addr1", 32'(rd_data), 32'h81);
        chk("ur_sticky", 32'(underrun), 32'd1);

        // Disable mid-row.
        dma_byte(8'h21, 1);
        dma_byte(8'h22, 1);
        wait_drq();
        enable = 1'b0;
        @(negedge clk);
        chk("dis_drq", 32'(drq), 32'd0);
        chk("dis_underrun", 32'(underrun), 32'd0);
        chk("dis_row_ready", 32'(row_ready), 32'd0);
        pulse_rs();
        repeat (3) @(negedge clk);
        chk("dis_rs_ignored", 32'(drq), 32'd0);
        rd_addr = 7'h02;
        @(negedge clk);
        chk("dis_rd_front", 32'(rd_data), 32'h82);

        // Async reset during XFER with iowe_n low.
        enable = 1'b1;
        pulse_rs();
        chk("rs_from_idle_ur", 32'(underrun), 32'd0);
        rd_addr = 7'h03;
        wait_drq();
        dack   = 1'b1;
        iowe_n = 1'b0;
        idata  = 8'h33;
        @(negedge clk);
        chk("pre_rst_rd", 32'(rd_data), 32'h03);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_drq", 32'(drq), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'h00);
        chk("arst_b_row_ready", 32'(b_row_ready), 32'd0);
        @(negedge clk);
        dack    = 1'b0;
        iowe_n  = 1'b1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_drq", 32'(drq), 32'd0);
        chk("post_rst_row_ready", 32'(row_ready), 32'd0);

        // Async reset while drq is high drops it before the next edge.
        pulse_rs();
        wait_drq();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_drq_high", 32'(drq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
